mtm_alu_frame_serializer: RTL and testbench



---
 rtl/mtm_alu_frame_serializer.sv | 135 +++++++++++++
 tb/tb_mtm_alu_frame_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_frame_serializer.sv
// Frame serializer: DATA_BYTES data packets then one control packet on sout.
// Define SER_PARITY_EN to add an even-parity bit to every packet.
module mtm_alu_frame_serializer #(
  parameter int DATA_BYTES = 4,
  parameter int GAP_BITS   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_BYTES*8-1:0] in_data,
  input  logic [7:0]              in_ctl,
  input  logic                    in_err,
  output logic                    sout,
  output logic                    busy
);

  localparam int BW = $clog2(DATA_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    TYPE,
    BITS,
`ifdef SER_PARITY_EN
    PAR,
`endif
    STOP,
    GAP,
    DONE
  } state_t;

  state_t                  state;
  logic [DATA_BYTES*8-1:0] data_q;
  logic [7:0]              ctl_q;
  logic [BW-1:0]           byte_cnt;
  logic [2:0]              bit_cnt;
  logic [3:0]              gap_cnt;
  logic [7:0]              cur_byte;

  assign in_ready = (state == IDLE);

  // byte_cnt counts down; the ctl byte goes out once it reaches zero
  always_comb begin
    cur_byte = ctl_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (byte_cnt == BW'(i + 1)) cur_byte = data_q[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sout     <= 1'b1;
      busy     <= 1'b0;
      data_q   <= '0;
      ctl_q    <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sout <= 1'b1;
          if (in_valid) begin
            data_q   <= in_data;
            ctl_q    <= in_ctl;
            byte_cnt <= in_err ? '0 : BW'(DATA_BYTES);
            sout     <= 1'b0;
            busy     <= 1'b1;
            state    <= TYPE;
          end
        end
        START: begin
          sout  <= 1'b0;
          state <= TYPE;
        end
        TYPE: begin
          sout    <= (byte_cnt == '0);
          bit_cnt <= 3'd7;
          state   <= BITS;
        end
        BITS: begin
          sout <= cur_byte[bit_cnt];
          if (bit_cnt == 3'd0) begin
`ifdef SER_PARITY_EN
            state <= PAR;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          sout  <= ^cur_byte;
          state <= STOP;
        end
`endif
        STOP: begin
          sout <= 1'b1;
          if (byte_cnt == '0) begin
            state <= DONE;
          end else begin
            byte_cnt <= byte_cnt - BW'(1);
            if (GAP_BITS > 0) begin
              gap_cnt <= 4'(GAP_BITS - 1);
              state   <= GAP;
            end else begin
              state <= START;
            end
          end
        end
        GAP: begin
          sout <= 1'b1;
          if (gap_cnt == 4'd0) state <= START;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        // stop bit of the ctl packet is on the line during this cycle
        DONE: begin
          sout  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          sout  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_frame_serializer.sv
// Scoreboard bench for mtm_alu_frame_serializer (default and 2-byte/gap-3 builds).
// Honours SER_PARITY_EN when the design is built with it.
module tb_mtm_alu_frame_serializer;

`ifdef SER_PARITY_EN
  localparam int P = 12;
`else
  localparam int P = 11;
`endif

  logic        clk;
  logic        rst_n;
  logic        v1, rdy1, e1, so1, b1;
  logic [31:0] d1;
  logic [7:0]  c1;
  logic        v2, rdy2, e2, so2, b2;
  logic [15:0] d2;
  logic [7:0]  c2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  int          st2[$];

  mtm_alu_frame_serializer #(.DATA_BYTES(4), .GAP_BITS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .in_ctl(c1), .in_err(e1), .sout(so1), .busy(b1)
  );

  mtm_alu_frame_serializer #(.DATA_BYTES(2), .GAP_BITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_ctl(c2), .in_err(e2), .sout(so2), .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bits after the start bit: type, payload MSB first, [parity], stop
  function automatic logic [11:0] pkt(input logic t, input logic [7:0] b);
`ifdef SER_PARITY_EN
    return {1'b0, t, b, ^b, 1'b1};
`else
    return {2'b00, t, b, 1'b1};
`endif
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic got(input int k, input logic [11:0] w);
    logic [11:0] e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_pkt dut%0d: got %h expected none", k, w);
    end else begin
      if (k == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("pkt_dut%0d", k), int'(w), int'(e));
    end
  endtask

  // monitor: deserialise each packet from both lines and score it
  logic        act[2];
  int          nb[2];
  logic [11:0] sh[2];
  initial begin
    logic sv;
    act[0] = 1'b0;
    act[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        sv = (k == 0) ? so1 : so2;
        if (!rst_n) begin
          act[k] = 1'b0;
        end else if (!act[k]) begin
          if (!sv) begin
            act[k] = 1'b1;
            nb[k]  = 0;
            sh[k]  = '0;
            if (k == 1) st2.push_back(cyc);
          end
        end else begin
          sh[k] = {sh[k][10:0], sv};
          nb[k]++;
          if (nb[k] == P - 1) begin
            act[k] = 1'b0;
            got(k, sh[k]);
          end
        end
      end
    end
  end

  task automatic wait_rdy1();
    int c = 0;
    while (!rdy1 && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("rdy1_timeout", int'(rdy1), 1);
  endtask

  // counts cycles with in_ready low after an accept; busy must track it
  task automatic count_low1(output int lowcnt, output int bmis);
    lowcnt = 0;
    bmis   = 0;
    while (!rdy1 && lowcnt < 500) begin
      lowcnt++;
      if (b1 !== 1'b1) bmis++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lowcnt, bmis, t0, t1, c, zc;
    rst_n = 1'b0;
    v1 = 0; e1 = 0; d1 = '0; c1 = '0;
    v2 = 0; e2 = 0; d2 = '0; c2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout1", int'(so1), 1);
    chk("rst_busy1", int'(b1), 0);
    chk("rst_rdy1", int'(rdy1), 1);
    chk("rst_sout2", int'(so2), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // data frame DEADBEEF / ctl 05
    @(negedge clk);
    d1 = 32'hDEADBEEF; c1 = 8'h05; e1 = 1'b0; v1 = 1'b1;
    q0.push_back(pkt(1'b0, 8'hDE));
    q0.push_back(pkt(1'b0, 8'hAD));
    q0.push_back(pkt(1'b0, 8'hBE));
    q0.push_back(pkt(1'b0, 8'hEF));
    q0.push_back(pkt(1'b1, 8'h05));
    @(posedge clk);
    #1;
    v1 = 1'b0; d1 = 32'h0; c1 = 8'hFF; e1 = 1'b1;
    count_low1(lowcnt, bmis);
    chk("data_ready_low", lowcnt, 5 * P);
    chk("data_busy_mirror", bmis, 0);
    chk("data_busy_end", int'(b1), 0);

    // error frame C9, in_data ignored
    @(negedge clk);
    d1 = 32'h12345678; c1 = 8'hC9; e1 = 1'b1; v1 = 1'b1;
    q0.push_back(pkt(1'b1, 8'hC9));
    @(posedge clk);
    #1;
    v1 = 1'b0;
    count_low1(lowcnt, bmis);
    chk("err_ready_low", lowcnt, P);
    chk("err_busy_mirror", bmis, 0);
    chk("err_sout_idle", int'(so1), 1);
    chk("err_ready_after", int'(rdy1), 1);

    // back-to-back with in_valid held high
    @(negedge clk);
    d1 = 32'hCAFEF00D; c1 = 8'h93; e1 = 1'b1; v1 = 1'b1;
    q0.push_back(pkt(1'b1, 8'h93));
    @(posedge clk);
    #1;
    t0 = cyc;
    d1 = 32'hFFFF0000; c1 = 8'hFF; e1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    d1 = 32'h11223344; c1 = 8'h5A;
    q0.push_back(pkt(1'b0, 8'h11));
    q0.push_back(pkt(1'b0, 8'h22));
    q0.push_back(pkt(1'b0, 8'h33));
    q0.push_back(pkt(1'b0, 8'h44));
    q0.push_back(pkt(1'b1, 8'h5A));
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (rdy1) break;
    end
    @(posedge clk);
    #1;
    t1 = cyc;
    v1 = 1'b0; d1 = 32'h0; c1 = 8'h0;
    chk("b2b_start_spacing", t1 - t0, P + 1);
    #1;
    chk("b2b_second_taken", int'(rdy1), 0);
    wait_rdy1();

    // asynchronous reset at bit 20 of a data frame
    @(negedge clk);
    d1 = 32'h12345678; c1 = 8'h66; e1 = 1'b0; v1 = 1'b1;
    q0.push_back(pkt(1'b0, 8'h12));
    @(posedge clk);
    #1;
    v1 = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("pre_reset_bit20", int'(so1), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sout", int'(so1), 1);
    chk("async_rst_busy", int'(b1), 0);
    chk("async_rst_rdy", int'(rdy1), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    zc = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (so1 !== 1'b1) zc++;
    end
    chk("post_rst_residual", zc, 0);
    chk("post_rst_ready", int'(rdy1), 1);

    // gap build: A55A, ctl 3C
    @(negedge clk);
    d2 = 16'hA55A; c2 = 8'h3C; e2 = 1'b0; v2 = 1'b1;
    q1.push_back(pkt(1'b0, 8'hA5));
    q1.push_back(pkt(1'b0, 8'h5A));
    q1.push_back(pkt(1'b1, 8'h3C));
    st2.delete();
    @(posedge clk);
    #1;
    v2 = 1'b0;
    lowcnt = 0;
    while (!rdy2 && lowcnt < 500) begin
      lowcnt++;
      @(posedge clk);
      #1;
    end
    chk("gap_frame_len", lowcnt, 3 * P + 2 * 3);
    chk("gap_busy_end", int'(b2), 0);
    chk("gap_starts", st2.size(), 3);
    if (st2.size() == 3) begin
      chk("gap_spacing1", st2[1] - st2[0], P + 3);
      chk("gap_spacing2", st2[2] - st2[1], P + 3);
    end

    // payload 07 / ctl 03 (parity 1 / 0 when enabled)
    @(negedge clk);
    d2 = 16'h0700; c2 = 8'h03; e2 = 1'b0; v2 = 1'b1;
    q1.push_back(pkt(1'b0, 8'h07));
    q1.push_back(pkt(1'b0, 8'h00));
    q1.push_back(pkt(1'b1, 8'h03));
    @(posedge clk);
    #1;
    v2 = 1'b0;
    c = 0;
    while (!rdy2 && c < 500) begin
      c++;
      @(posedge clk);
      #1;
    end
    chk("par_frame_len", c, 3 * P + 2 * 3);

    repeat (20) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
